// File: rtl/dnoc_pkg.sv
// Shared types and constants for the dmem ping/pong buffer ownership logic.
package dnoc_pkg;

    typedef enum logic [1:0] {
        BufEmpty   = 2'd0,
        BufFilling = 2'd1,
        BufFull    = 2'd2
    } pp_buf_state_e;

    typedef enum logic [1:0] {
        TopIdle   = 2'd0,
        TopActive = 2'd1,
        TopDone   = 2'd2
    } pp_top_state_e;

    localparam logic PP_PING = 1'b0;
    localparam logic PP_PONG = 1'b1;

endpackage

// File: rtl/dnoc_pp_buf_slot.sv
// One ping/pong buffer: EMPTY -> FILLING -> FULL -> EMPTY, advanced by qualified strobes.
module dnoc_pp_buf_slot
    import dnoc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          grant_i,
    input  logic          wr_done_i,
    input  logic          rd_done_i,
    output pp_buf_state_e state_o,
    output logic          full_o
);

    pp_buf_state_e state_q, state_d;

    // Strobes are pre-qualified by the controller, so at most one can match the current state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BufEmpty:   if (grant_i)   state_d = BufFilling;
            BufFilling: if (wr_done_i) state_d = BufFull;
            BufFull:    if (rd_done_i) state_d = BufEmpty;
            default:                   state_d = BufEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BufEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign full_o  = (state_q == BufFull);

endmodule

// File: rtl/dnoc_pingpong_ctrl.sv
// Ping/pong buffer ownership tracker between the dmem writer and the core read path.
module dnoc_pingpong_ctrl
    import dnoc_pkg::*;
#(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_pingpong_en,
    input  logic [CNT_W-1:0] cfg_pingpong_num,
    input  logic             start,
    input  logic             wr_buf_req,
    output logic             wr_buf_gnt,
    output logic             wr_buf_sel,
    input  logic             wr_done,
    output logic [1:0]       pingpong_state,
    input  logic             pingpong_rd_done,
    output logic             busy,
    output logic             xfer_done,
    output logic             err_wr,
    output logic             err_rd,
    input  logic             err_clr
);

    localparam logic [1:0]   StIdle   = TopIdle;
    localparam logic [1:0]   StActive = TopActive;
    localparam logic [1:0]   StDone   = TopDone;
    localparam logic [CNT_W:0] CntOne = 1;

    logic [1:0]     state_q, state_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [CNT_W:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W:0] total_q, total_d;
    logic           err_wr_q, err_wr_d;
    logic           err_rd_q, err_rd_d;

    pp_buf_state_e  buf_state [2];
    logic [1:0]     buf_full;
    logic [1:0]     slot_grant, slot_wr_done, slot_rd_done;

    logic bypass, any_filling, fill_idx, grant, wr_ok, rd_ok;

    assign bypass      = (state_q == StIdle) && !cfg_pingpong_en;
    assign any_filling = (buf_state[PP_PING] == BufFilling) || (buf_state[PP_PONG] == BufFilling);
    assign fill_idx    = (buf_state[PP_PONG] == BufFilling);
    assign grant       = (state_q == StActive) && wr_buf_req &&
                         (buf_state[wr_ptr_q] == BufEmpty) && (wr_cnt_q < total_q) &&
                         !any_filling;
    assign wr_ok       = wr_done && any_filling;
    assign rd_ok       = pingpong_rd_done && (buf_state[rd_ptr_q] == BufFull);

    for (genvar i = 0; i < 2; i++) begin : g_slot
        assign slot_grant[i]   = grant && (wr_ptr_q == 1'(i));
        assign slot_wr_done[i] = wr_ok && (fill_idx == 1'(i));
        assign slot_rd_done[i] = rd_ok && (rd_ptr_q == 1'(i));

        dnoc_pp_buf_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .grant_i   (slot_grant[i]),
            .wr_done_i (slot_wr_done[i]),
            .rd_done_i (slot_rd_done[i]),
            .state_o   (buf_state[i]),
            .full_o    (buf_full[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        total_d  = total_q;

        case (state_q)
            StIdle: begin
                if (start && cfg_pingpong_en) begin
                    total_d  = {cfg_pingpong_num, 1'b0};
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    wr_ptr_d = PP_PING;
                    rd_ptr_d = PP_PING;
                    state_d  = (cfg_pingpong_num == '0) ? StDone : StActive;
                end
            end
            StActive: if (rd_cnt_q == total_q) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (wr_ok) begin
            wr_ptr_d = ~wr_ptr_q;
            wr_cnt_d = wr_cnt_q + CntOne;
        end
        if (rd_ok) begin
            rd_ptr_d = ~rd_ptr_q;
            rd_cnt_d = rd_cnt_q + CntOne;
        end
    end

    // In bypass the reader sees both buffers FULL, so its rd_done pulses are legal.
    always_comb begin
        err_wr_d = err_wr_q || (wr_done && !any_filling);
        err_rd_d = err_rd_q || (pingpong_rd_done && !bypass && !rd_ok);
        if (err_clr) begin
            err_wr_d = 1'b0;
            err_rd_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= PP_PING;
            rd_ptr_q <= PP_PING;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            total_q  <= '0;
            err_wr_q <= 1'b0;
            err_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            total_q  <= total_d;
            err_wr_q <= err_wr_d;
            err_rd_q <= err_rd_d;
        end
    end

    assign wr_buf_gnt     = bypass ? wr_buf_req : grant;
    assign wr_buf_sel     = bypass ? 1'b0 : (any_filling ? fill_idx : wr_ptr_q);
    assign pingpong_state = bypass ? 2'b11 : buf_full;
    assign busy           = (state_q != StIdle);
    assign xfer_done      = (state_q == StDone);
    assign err_wr         = err_wr_q;
    assign err_rd         = err_rd_q;

endmodule

// File: tb/tb_dnoc_pingpong_ctrl.sv
// Self-checking bench for dnoc_pingpong_ctrl: grant-select and buffer-state scoreboards.
module tb_dnoc_pingpong_ctrl;

    localparam int unsigned CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en, start, req, wr_done, rd_done, err_clr;
    logic [CNT_W-1:0] num;
    logic             gnt, sel, busy, xfer, err_wr, err_rd;
    logic [1:0]       pp_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic       exp_sel_q   [$];
    logic [1:0] exp_state_q [$];

    dnoc_pingpong_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_pingpong_en  (en),
        .cfg_pingpong_num (num),
        .start            (start),
        .wr_buf_req       (req),
        .wr_buf_gnt       (gnt),
        .wr_buf_sel       (sel),
        .wr_done          (wr_done),
        .pingpong_state   (pp_state),
        .pingpong_rd_done (rd_done),
        .busy             (busy),
        .xfer_done        (xfer),
        .err_wr           (err_wr),
        .err_rd           (err_rd),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [CNT_W-1:0] n);
        en = 1'b1; num = n; start = 1'b1;
        cycle();
        start = 1'b0;
        num = 11'd7;  // must be ignored until the next IDLE
    endtask

    // Raise req, wait (bounded) for a grant and compare the granted buffer.
    task automatic grant_buf(input string tag, input logic exp_sel);
        logic e;
        bit   seen;
        seen = 1'b0;
        exp_sel_q.push_back(exp_sel);
        req = 1'b1;
        #1;
        for (int k = 0; k < 16 && !seen; k++) begin
            if (gnt === 1'b1) seen = 1'b1;
            else cycle();
        end
        e = exp_sel_q.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s grant: no grant within 16 cycles, required sel %0d", tag, e);
        end else if (sel !== e) begin
            n_fail++;
            $display("FAIL %s grant_sel: got %0d required %0d", tag, sel, e);
        end
        cycle();
        req = 1'b0;
    endtask

    task automatic pulse(input string tag, input logic w, input logic r, input logic [1:0] exp);
        logic [1:0] e;
        wr_done = w; rd_done = r;
        exp_state_q.push_back(exp);
        cycle();
        wr_done = 1'b0; rd_done = 1'b0;
        e = exp_state_q.pop_front();
        n_checks++;
        if (pp_state !== e) begin
            n_fail++;
            $display("FAIL %s pingpong_state: got %b required %b", tag, pp_state, e);
        end
    endtask

    // Called right after the cycle in which rd_cnt reached total.
    task automatic expect_done(input string tag);
        n_checks++;
        if (xfer !== 1'b0) begin
            n_fail++; $display("FAIL %s xfer_early: got %b required 0", tag, xfer);
        end
        cycle();
        n_checks++;
        if ({xfer, busy} !== 2'b11) begin
            n_fail++; $display("FAIL %s done_cycle: got xfer,busy=%b required 11", tag, {xfer, busy});
        end
        cycle();
        n_checks++;
        if ({xfer, busy} !== 2'b00) begin
            n_fail++; $display("FAIL %s after_done: got xfer,busy=%b required 00", tag, {xfer, busy});
        end
    endtask

    task automatic run_pair(input string tag);
        grant_buf(tag, 1'b0);
        pulse(tag, 1'b1, 1'b0, 2'b01);
        grant_buf(tag, 1'b1);
        pulse(tag, 1'b1, 1'b0, 2'b11);
        pulse(tag, 1'b0, 1'b1, 2'b10);
        pulse(tag, 1'b0, 1'b1, 2'b00);
        expect_done(tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; num = '0; start = 0; req = 0;
        wr_done = 0; rd_done = 0; err_clr = 0;
        #12;
        n_checks++;
        if ({gnt, sel, pp_state, busy, xfer, err_wr, err_rd} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {gnt, sel, pp_state, busy, xfer, err_wr, err_rd});
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic_pair();
        start_xfer(11'd1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL basic busy: got %b required 1", busy);
        end
        run_pair("basic");
    endtask

    task automatic test_back_pressure();
        start_xfer(11'd2);
        grant_buf("bp", 1'b0);
        pulse("bp", 1'b1, 1'b0, 2'b01);
        grant_buf("bp", 1'b1);
        pulse("bp", 1'b1, 1'b0, 2'b11);
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (gnt !== 1'b0) begin
                n_fail++; $display("FAIL bp held_gnt: got %b required 0", gnt);
            end
        end
        pulse("bp", 1'b0, 1'b1, 2'b10);
        n_checks++;
        if (gnt !== 1'b1) begin
            n_fail++; $display("FAIL bp turnaround_gnt: got %b required 1", gnt);
        end
        grant_buf("bp", 1'b0);
        pulse("bp", 1'b1, 1'b0, 2'b11);
        pulse("bp", 1'b0, 1'b1, 2'b01);
        grant_buf("bp", 1'b1);
        pulse("bp", 1'b1, 1'b0, 2'b11);
        pulse("bp", 1'b0, 1'b1, 2'b10);
        pulse("bp", 1'b0, 1'b1, 2'b00);
        expect_done("bp");
    endtask

    task automatic test_simultaneous();
        start_xfer(11'd1);
        grant_buf("sim", 1'b0);
        pulse("sim", 1'b1, 1'b0, 2'b01);
        grant_buf("sim", 1'b1);
        pulse("sim", 1'b1, 1'b1, 2'b10);
        // Both counters advanced: rd_ptr now on pong, and one more read completes the pair.
        pulse("sim", 1'b0, 1'b1, 2'b00);
        expect_done("sim");
    endtask

    task automatic test_errors();
        start_xfer(11'd1);
        pulse("err", 1'b0, 1'b1, 2'b00);
        n_checks++;
        if ({err_wr, err_rd} !== 2'b01) begin
            n_fail++; $display("FAIL err rd_set: got %b required 01", {err_wr, err_rd});
        end
        pulse("err", 1'b1, 1'b0, 2'b00);
        n_checks++;
        if ({err_wr, err_rd} !== 2'b11) begin
            n_fail++; $display("FAIL err wr_set: got %b required 11", {err_wr, err_rd});
        end
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        n_checks++;
        if ({err_wr, err_rd} !== 2'b00) begin
            n_fail++; $display("FAIL err clear: got %b required 00", {err_wr, err_rd});
        end
        err_clr = 1'b1;
        pulse("err", 1'b0, 1'b1, 2'b00);
        err_clr = 1'b0;
        n_checks++;
        if (err_rd !== 1'b0) begin
            n_fail++; $display("FAIL err clr_priority: got %b required 0", err_rd);
        end
        run_pair("err");
    endtask

    task automatic test_bypass_zero();
        en = 1'b0; num = 11'd3;
        #1;
        n_checks++;
        if (pp_state !== 2'b11) begin
            n_fail++; $display("FAIL bypass state: got %b required 11", pp_state);
        end
        req = 1'b1; #1;
        n_checks++;
        if ({gnt, sel} !== 2'b10) begin
            n_fail++; $display("FAIL bypass gnt_sel: got %b required 10", {gnt, sel});
        end
        req = 1'b0; #1;
        n_checks++;
        if (gnt !== 1'b0) begin
            n_fail++; $display("FAIL bypass gnt_low: got %b required 0", gnt);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL bypass start_ignored: got busy %b required 0", busy);
        end
        en = 1'b1; num = '0; start = 1'b1; req = 1'b1;
        cycle();
        start = 1'b0;
        n_checks++;
        if ({xfer, busy, gnt} !== 3'b110) begin
            n_fail++; $display("FAIL zero done: got xfer,busy,gnt=%b required 110", {xfer, busy, gnt});
        end
        cycle();
        req = 1'b0;
        n_checks++;
        if ({xfer, busy} !== 2'b00) begin
            n_fail++; $display("FAIL zero idle: got %b required 00", {xfer, busy});
        end
    endtask

    task automatic test_reset_mid();
        start_xfer(11'd1);
        grant_buf("rst", 1'b0);
        pulse("rst", 1'b1, 1'b0, 2'b01);
        req = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, sel, pp_state, busy, xfer, err_wr, err_rd} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst mid_outputs: got %b required 00000000",
                     {gnt, sel, pp_state, busy, xfer, err_wr, err_rd});
        end
        req = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        start_xfer(11'd1);
        run_pair("rst_clean");
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_back_pressure();
        test_simultaneous();
        test_errors();
        test_bypass_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
